cordic_cos_sin_arbiter: RTL
===========================

Name: cordic_cos_sin_arbiter

Overview:
Shares one cordicCosSinParallel pipeline (latency LAT = N + 2 clocks, one start per clock) between N_REQ independent requesters. Round-robin arbitration issues at most one angle per clock. An in-order tag delay line tracks which requester owns each in-flight sample. Each completed cos/sin pair is returned to its requester through a one-entry result register with a valid/ready handshake.

Parameters:
N_REQ, 4, number of requesters (2..16)
PHI_WDT, 16, angle and result width; must equal the pipeline's PHI_WDT
LAT, 18, pipeline latency in clocks; must equal pipeline N + 2
ID_WDT, $clog2(N_REQ), tag width (derived, not overridable)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
sclr  in  1  sync clear; acts only when en = 1
en  in  1  clock enable; en = 0 freezes all state
req_vld  in  N_REQ  request valid, per requester
req_rdy  out  N_REQ  request accepted this cycle (one-hot or zero)
req_phi  in  N_REQ*PHI_WDT  angles; requester i at bits [i*PHI_WDT +: PHI_WDT]
res_vld  out  N_REQ  result valid, per requester
res_rdy  in  N_REQ  result consumed, per requester
res_cos  out  N_REQ*PHI_WDT  per-requester cos, same packing as req_phi
res_sin  out  N_REQ*PHI_WDT  per-requester sin
cs_en  out  1  to pipeline en (equals en)
cs_sclr  out  1  to pipeline sclr (equals sclr)
cs_st  out  1  to pipeline st
cs_phi  out  PHI_WDT  to pipeline phi
cs_rdy  in  1  from pipeline rdy
cs_cos  in  PHI_WDT  from pipeline cos
cs_sin  in  PHI_WDT  from pipeline sin
err  out  1  sticky tag/rdy mismatch flag

Behaviour:
- Reset (reset_n = 0, async): res_vld = 0, res_cos = res_sin = 0, busy = 0, tag line cleared, err = 0, round-robin pointer = N_REQ-1, so requester 0 has first priority.
- busy[i] = inflight[i] OR res_vld[i]. A requester has at most one outstanding sample, so result slots can never overflow.
- Eligibility: eligible[i] = req_vld[i] AND NOT busy[i]. Grant is combinational and goes to the first eligible index searching upward from pointer+1 with wrap-around.
- The grant is suppressed when en = 0 or sclr = 1.
- req_rdy = grant vector. Handshake completes when req_vld[i] AND req_rdy[i].
- Issue cycle: cs_st = 1 and cs_phi = req_phi[g] (combinational). Otherwise cs_st = 0 and cs_phi = 0.
- On the issue edge: inflight[g] <= 1 and pointer <= g.
- Tag line: LAT stages of {valid, id}, shifted when en = 1. Stage 0 is loaded with {cs_st, g}.
- Stage LAT-1 aligns with cs_rdy, so a sample issued in cycle t sees cs_rdy in cycle t+LAT.
- Completion: when cs_rdy = 1 and the tag output is valid with id k, then res_cos[k] <= cs_cos, res_sin[k] <= cs_sin, res_vld[k] <= 1, inflight[k] <= 0.
- Latency from accept to res_vld: LAT + 1 clocks.
- Result handshake: res_vld[k] AND res_rdy[k] clears res_vld[k] on the next edge. Data holds until then.
- The freed requester becomes eligible again one cycle after res_vld falls. Because busy is registered, grant and consume cannot collide.
- Mismatch: if cs_rdy differs from the tag output valid, err <= 1 (sticky) and no result is written.
- sclr with en = 1 clears busy, the tag line, res_vld and err, and resets the pointer. The pipeline is flushed via cs_sclr in the same cycle. Results in flight are discarded and never appear.
- en = 0: no grants, no state change. req_rdy = 0 and res_vld is held. Outputs keep their values.
- reset_n asserted mid-operation returns everything to reset values immediately.

Test Plan:
- Single request: N_REQ = 4, LAT = 18, requester 0 sends phi = 0x0000 at cycle 0 -> req_rdy[0] at cycle 0; res_vld[0] at cycle 19; cos within 4 LSB of 32767, sin within 4 LSB of 0; res_cos/res_sin equal to a directly driven reference pipeline.
- All four requesters hold req_vld continuously, res_rdy = 1 -> grants 0,1,2,3 in cycles 0..3; each requester is regranted only after its res_vld handshake; the order is fair with no starvation over 200 cycles.
- Requester 2 with res_rdy = 0 -> res_vld[2] and its data hold indefinitely; requester 2 receives no further grant; requesters 0, 1, 3 continue to be served.
- phi = 0x4000 on requester 1 while requester 3 issues phi = 0xC000 the next cycle -> res[1] sin ≈ +32767, res[3] sin ≈ -32767, each routed to the correct slot in issue order.
- sclr pulse 5 cycles after three issues -> no res_vld for those samples ever; err stays 0; new requests after sclr complete normally.
- en held low for 7 cycles mid-flight -> all results are delayed by exactly 7 cycles with identical values. Separately, forcing cs_rdy = 1 with no sample in flight -> err = 1 until sclr.

Source files
------------

// File: rtl/cordic_cos_sin_arbiter.sv
// Round-robin front end sharing one cordicCosSinParallel pipeline between N_REQ requesters.
// In-order tag line routes each pipeline result back to its requester's one-entry result slot.
module cordic_cos_sin_slot #(
    parameter int PHI_WDT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               sclr,
    input  logic               issue,
    input  logic               done,
    input  logic               rdy,
    input  logic [PHI_WDT-1:0] cos_in,
    input  logic [PHI_WDT-1:0] sin_in,
    output logic               vld,
    output logic               busy,
    output logic [PHI_WDT-1:0] cos_q,
    output logic [PHI_WDT-1:0] sin_q
);
    logic inflight;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 1'b0;
            vld      <= 1'b0;
            cos_q    <= '0;
            sin_q    <= '0;
        end else if (en) begin
            if (sclr) begin
                inflight <= 1'b0;
                vld      <= 1'b0;
            end else begin
                if (issue)
                    inflight <= 1'b1;
                if (vld && rdy)
                    vld <= 1'b0;
                // done never coincides with vld: a busy slot cannot be reissued
                if (done) begin
                    inflight <= 1'b0;
                    vld      <= 1'b1;
                    cos_q    <= cos_in;
                    sin_q    <= sin_in;
                end
            end
        end
    end

    assign busy = inflight | vld;
endmodule

module cordic_cos_sin_arbiter #(
    parameter int N_REQ   = 4,
    parameter int PHI_WDT = 16,
    parameter int LAT     = 18
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sclr,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req_vld,
    output logic [N_REQ-1:0]         req_rdy,
    input  logic [N_REQ*PHI_WDT-1:0] req_phi,
    output logic [N_REQ-1:0]         res_vld,
    input  logic [N_REQ-1:0]         res_rdy,
    output logic [N_REQ*PHI_WDT-1:0] res_cos,
    output logic [N_REQ*PHI_WDT-1:0] res_sin,
    output logic                     cs_en,
    output logic                     cs_sclr,
    output logic                     cs_st,
    output logic [PHI_WDT-1:0]       cs_phi,
    input  logic                     cs_rdy,
    input  logic [PHI_WDT-1:0]       cs_cos,
    input  logic [PHI_WDT-1:0]       cs_sin,
    output logic                     err
);
    localparam int ID_WDT = $clog2(N_REQ);

    logic [N_REQ-1:0][PHI_WDT-1:0] phi_a, cos_a, sin_a;
    logic [N_REQ-1:0]              busy, grant, done;
    logic [ID_WDT-1:0]             ptr, gid;
    logic [LAT-1:0]                vld_pipe;
    logic [LAT-1:0][ID_WDT-1:0]    id_pipe;

    assign phi_a = req_phi;

    // Scan from the far end so the nearest eligible index after ptr wins last
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        gid   = '0;
        if (en && !sclr) begin
            for (int j = N_REQ; j >= 1; j--) begin
                idx = int'(ptr) + j;
                if (idx >= N_REQ)
                    idx = idx - N_REQ;
                if (req_vld[idx] && !busy[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    gid        = ID_WDT'(idx);
                end
            end
        end
    end

    assign req_rdy = grant;
    assign cs_st   = |grant;
    assign cs_phi  = cs_st ? phi_a[gid] : '0;
    assign cs_en   = en;
    assign cs_sclr = sclr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            ptr      <= ID_WDT'(N_REQ-1);
            err      <= 1'b0;
        end else if (en) begin
            if (sclr) begin
                vld_pipe <= '0;
                id_pipe  <= '0;
                ptr      <= ID_WDT'(N_REQ-1);
                err      <= 1'b0;
            end else begin
                vld_pipe <= {vld_pipe[LAT-2:0], cs_st};
                id_pipe  <= {id_pipe[LAT-2:0], gid};
                if (cs_st)
                    ptr <= gid;
                if (cs_rdy != vld_pipe[LAT-1])
                    err <= 1'b1;
            end
        end
    end

    // A tag/rdy disagreement writes nothing
    always_comb begin
        done = '0;
        if (cs_rdy && vld_pipe[LAT-1])
            done[id_pipe[LAT-1]] = 1'b1;
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        cordic_cos_sin_slot #(.PHI_WDT(PHI_WDT)) u_slot (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (en),
            .sclr   (sclr),
            .issue  (grant[i]),
            .done   (done[i]),
            .rdy    (res_rdy[i]),
            .cos_in (cs_cos),
            .sin_in (cs_sin),
            .vld    (res_vld[i]),
            .busy   (busy[i]),
            .cos_q  (cos_a[i]),
            .sin_q  (sin_a[i])
        );
    end

    assign res_cos = cos_a;
    assign res_sin = sin_a;
endmodule
